layer_4_conv_scheduler: RTL and testbench

LAYER_4_CONV_SCHEDULER -- requirements
Module: layer_4_conv_scheduler

---
 rtl/yolo_sched_pkg.sv | 21 ++
 rtl/pixel_coord_counter.sv | 57 +++++
 rtl/layer_4_conv_scheduler.sv | 115 +++++++++++
 tb/tb_layer_4_conv_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_sched_pkg.sv
// Shared definitions for the layer-4 convolution scheduler: FSM encoding
// and the per-featuremap pixel count.
package yolo_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } sched_state_e;

  localparam int IMG_SIZE_DEF  = 104;
  localparam int PIX_COUNT_DEF = IMG_SIZE_DEF * IMG_SIZE_DEF;

  // Pixels (and therefore conv outputs) per featuremap pass.
  function automatic int pix_count(input int img);
    return img * img;
  endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster row/col counter for one featuremap pass. Wraps to (0,0) after the
// last pixel; last_o flags that the current coordinate is the final one.
module pixel_coord_counter #(
  parameter  int IMG_SIZE = 104,
  localparam int CW       = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);

  localparam logic [CW-1:0] MAX = CW'(IMG_SIZE - 1);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          col_wrap, row_wrap;

  assign col_wrap = (col_q == MAX);
  assign row_wrap = (row_q == MAX);

  // Next coordinate: clear wins over increment; col carries into row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_wrap ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_wrap & row_wrap;

endmodule

// File: rtl/layer_4_conv_scheduler.sv
// Sequences NUM_FM featuremap passes over an IMG_SIZE x IMG_SIZE frame:
// loads weights, streams pixels into the external Conv2D3x3 bank, then
// waits for every output of the pass before moving on.
module layer_4_conv_scheduler
  import yolo_sched_pkg::*;
#(
  parameter  int IMG_SIZE = 104,
  parameter  int NUM_FM   = 64,
  parameter  int CNT_W    = 14,
  localparam int FM_W     = (NUM_FM > 1) ? $clog2(NUM_FM) : 1,
  localparam int CW       = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            pix_valid_i,
  output logic            pix_ready_o,
  output logic            conv_valid_in_o,
  input  logic            conv_valid_out_i,
  output logic [FM_W-1:0] fm_sel_o,
  output logic            cfg_load_o,
  output logic [CW-1:0]   row_o,
  output logic [CW-1:0]   col_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int               PIX_COUNT = pix_count(IMG_SIZE);
  localparam logic [CNT_W-1:0] PIX_C     = CNT_W'(PIX_COUNT);
  localparam logic [FM_W-1:0]  LAST_FM   = FM_W'(NUM_FM - 1);

  sched_state_e state_q, state_d;

  logic [FM_W-1:0]  fm_sel_q, fm_sel_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             err_q, err_d;

  logic xfer, last_pix, cnt_inc, drain_exit, last_fm, out_in_quiet;

  assign xfer         = pix_valid_i & pix_ready_o;
  assign cnt_inc      = conv_valid_out_i & ((state_q == ST_STREAM) | (state_q == ST_DRAIN));
  assign out_in_quiet = conv_valid_out_i &
                        ((state_q == ST_IDLE) | (state_q == ST_LOAD) | (state_q == ST_DONE));
  // Looking at the next count lets DRAIN leave in the same cycle the
  // final output arrives.
  assign drain_exit   = (out_cnt_d >= PIX_C);
  assign last_fm      = (fm_sel_q == LAST_FM);

  pixel_coord_counter #(.IMG_SIZE(IMG_SIZE)) u_coord (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (xfer),
    .clr_i  (state_q == ST_LOAD),
    .row_o  (row_o),
    .col_o  (col_o),
    .last_o (last_pix)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_STREAM;
      ST_STREAM: if (xfer && last_pix) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_exit) state_d = last_fm ? ST_DONE : ST_LOAD;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the current state only.
  always_comb begin
    pix_ready_o = (state_q == ST_STREAM);
    cfg_load_o  = (state_q == ST_LOAD);
    busy_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_DONE);
  end

  // Featuremap index, output counter and sticky error next-state.
  always_comb begin
    fm_sel_d  = fm_sel_q;
    out_cnt_d = out_cnt_q;
    if (state_q == ST_LOAD)  out_cnt_d = '0;
    else if (cnt_inc)        out_cnt_d = out_cnt_q + 1'b1;
    if (state_q == ST_DRAIN && drain_exit && !last_fm) fm_sel_d = fm_sel_q + 1'b1;
    if (state_q == ST_DONE)  fm_sel_d = '0;
    err_d = err_q | out_in_quiet | (cnt_inc & (out_cnt_q >= PIX_C));
  end

  // Featuremap index, output counter and sticky error registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fm_sel_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      fm_sel_q  <= fm_sel_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  assign conv_valid_in_o = xfer;
  assign fm_sel_o        = fm_sel_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_layer_4_conv_scheduler.sv
// Scoreboard bench: expected weight loads and pixel coordinates are queued
// when a frame is launched and popped as the scheduler emits them.
module tb_layer_4_conv_scheduler;

  localparam int IMG = 4;
  localparam int NFM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, pix_valid = 1'b0, cvo_force = 1'b0;
  logic pix_ready, conv_valid_in, conv_valid_out, cfg_load, busy, done, err;
  logic [0:0] fm_sel;
  logic [1:0] row, col;

  logic start1 = 1'b0, pix_valid1 = 1'b0;
  logic pix_ready1, cvi1, cfg_load1, busy1, done1, err1;
  logic [0:0] fm_sel1;
  logic [1:0] row1, col1;

  logic [2:0] pipe;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_out_cyc = -100, out_cnt_tb = 0, done_cnt = 0, done1_cnt = 0;
  int xfer_cnt [NFM];
  int pix_q [$];
  int cfg_q [$];
  int e_pix, e_cfg;

  always #5 clk = ~clk;

  layer_4_conv_scheduler #(.IMG_SIZE(IMG), .NUM_FM(NFM), .CNT_W(14)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pix_valid_i(pix_valid),
    .pix_ready_o(pix_ready), .conv_valid_in_o(conv_valid_in),
    .conv_valid_out_i(conv_valid_out), .fm_sel_o(fm_sel), .cfg_load_o(cfg_load),
    .row_o(row), .col_o(col), .busy_o(busy), .done_o(done), .err_o(err)
  );

  // Zero-latency loopback instance with a single featuremap.
  layer_4_conv_scheduler #(.IMG_SIZE(IMG), .NUM_FM(1), .CNT_W(14)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .pix_valid_i(pix_valid1),
    .pix_ready_o(pix_ready1), .conv_valid_in_o(cvi1),
    .conv_valid_out_i(cvi1), .fm_sel_o(fm_sel1), .cfg_load_o(cfg_load1),
    .row_o(row1), .col_o(col1), .busy_o(busy1), .done_o(done1), .err_o(err1)
  );

  // Conv bank model: every input comes back three cycles later.
  always @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[1:0], conv_valid_in};
  end
  assign conv_valid_out = pipe[2] | cvo_force;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (cfg_load) begin
        e_cfg = (cfg_q.size() > 0) ? cfg_q.pop_front() : 999;
        chk("cfg_fm", 32'(fm_sel), e_cfg);
      end
      if (conv_valid_in) begin
        xfer_cnt[fm_sel]++;
        e_pix = (pix_q.size() > 0) ? pix_q.pop_front() : 999;
        chk("pix_coord", 32'({fm_sel, row, col}), e_pix);
      end
      if (conv_valid_out) begin
        out_cnt_tb++;
        last_out_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_lat", cyc - last_out_cyc, 1);
        chk("done_outs", out_cnt_tb, NFM * IMG * IMG);
      end
      if (done1) done1_cnt++;
    end
  end

  task automatic load_expect();
    pix_q.delete();
    cfg_q.delete();
    for (int f = 0; f < NFM; f++) begin
      cfg_q.push_back(f);
      xfer_cnt[f] = 0;
      for (int r = 0; r < IMG; r++)
        for (int c = 0; c < IMG; c++)
          pix_q.push_back(f * 16 + r * 4 + c);
    end
    out_cnt_tb = 0;
  endtask

  task automatic run_frame(input bit toggle, input int restart_at);
    int d0;
    bit seen;
    load_expect();
    d0 = done_cnt;
    seen = 1'b0;
    start = 1'b1; pix_valid = 1'b0;
    step();
    start = 1'b0;
    chk("lat_cfg_load", cfg_load, 1);
    chk("lat_fm_sel0", fm_sel, 0);
    chk("lat_ready_lo", pix_ready, 0);
    pix_valid = 1'b1;
    step();
    chk("lat_ready_hi", pix_ready, 1);
    for (int k = 0; k < 400; k++) begin
      pix_valid = toggle ? k[0] : 1'b1;
      start = (k == restart_at);
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0; pix_valid = 1'b0;
    chk("frame_done_seen", seen, 1);
    repeat (4) step();
    chk("done_once", done_cnt - d0, 1);
    chk("xfers_fm0", xfer_cnt[0], IMG * IMG);
    chk("xfers_fm1", xfer_cnt[1], IMG * IMG);
    chk("pix_q_left", pix_q.size(), 0);
    chk("cfg_q_left", cfg_q.size(), 0);
    chk("end_err", err, 0);
    chk("end_busy", busy, 0);
    chk("end_fm_sel", fm_sel, 0);
    chk("end_row", row, 0);
    chk("end_col", col, 0);
  endtask

  initial begin
    int k, d0, n;
    rst = 1'b1;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_ready", pix_ready, 0);
    chk("rst_cfg_load", cfg_load, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();
    chk("post_rst_err", err, 0);
    chk("post_rst_fm", fm_sel, 0);
    chk("post_rst_row", row, 0);
    chk("post_rst_col", col, 0);

    run_frame(1'b0, -1);   // valid held high
    run_frame(1'b1, -1);   // valid toggling
    run_frame(1'b0, 3);    // start re-pulsed during STREAM

    // Abort at the 7th transfer of the first pass.
    load_expect();
    d0 = done_cnt;
    k = 0;
    start = 1'b1; step(); start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (conv_valid_in) k++;
      if (k == 7) break;
    end
    chk("abort_reach", k, 7);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", pix_ready, 0);
    chk("abort_row", row, 0);
    chk("abort_col", col, 0);
    step();
    chk("abort_start_ign", busy, 0);
    repeat (4) step();
    chk("abort_no_done", done_cnt - d0, 0);
    run_frame(1'b0, -1);   // new frame after abort

    // Single-featuremap loopback: STREAM -> DRAIN (1 cycle) -> DONE.
    start1 = 1'b1; pix_valid1 = 1'b1;
    step();
    start1 = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && n < IMG * IMG; i++) begin
      step();
      if (cvi1) n++;
    end
    chk("lb_xfers", n, IMG * IMG);
    step();
    chk("lb_drain_busy", busy1, 1);
    chk("lb_drain_ready", pix_ready1, 0);
    chk("lb_drain_cfg", cfg_load1, 0);
    chk("lb_drain_done", done1, 0);
    step();
    chk("lb_done", done1, 1);
    step();
    pix_valid1 = 1'b0;
    chk("lb_done_clr", done1, 0);
    chk("lb_idle", busy1, 0);
    chk("lb_err", err1, 0);
    chk("lb_fm_sel", fm_sel1, 0);
    chk("lb_row", row1, 0);
    chk("lb_col", col1, 0);
    repeat (3) step();
    chk("lb_done_cnt", done1_cnt, 1);

    // Output while idle sets err until reset.
    cvo_force = 1'b1;
    step();
    cvo_force = 1'b0;
    chk("err_set", err, 1);
    repeat (3) step();
    chk("err_sticky", err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_rst", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
